boneless_mem_arbiter: RTL and testbench

//  Shares the Boneless main memory (one sync read port, one write port, 16-bit words) between
//  the CPU and a second requester (DMA/debug). The CPU has priority. A per-port starvation

---
 rtl/boneless_mem_arb_pkg.sv | 24 ++
 rtl/boneless_arb_port.sv | 65 ++++++
 rtl/boneless_mem_arbiter.sv | 96 +++++++++
 tb/tb_boneless_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/boneless_mem_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// boneless_mem_arb_pkg : shared types and helpers for the memory arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
package boneless_mem_arb_pkg;

  typedef enum logic [0:0] {
    ARB_CPU_PRI = 1'b0,
    ARB_DMA_PRI = 1'b1
  } arb_state_t;

  // Bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/boneless_arb_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// boneless_arb_port : CPU-priority arbiter for one memory port with DMA anti-starvation
// Revision: 1.0
// ---------------------------------------------------------------------------
module boneless_arb_port
  import boneless_mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic dma_req,
  output logic cpu_win,
  output logic dma_win
);

  localparam int CW = clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_nxt;
  logic          contend;

  assign contend = cpu_req & dma_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB_CPU_PRI;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    cpu_win      = 1'b0;
    dma_win      = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;

    if (contend) begin
      if (state == ARB_DMA_PRI) dma_win = 1'b1;
      else                      cpu_win = 1'b1;
    end else begin
      cpu_win = cpu_req;
      dma_win = dma_req;
    end

    // A served DMA request restarts the fairness window.
    if (dma_win) begin
      wait_cnt_nxt = '0;
      state_nxt    = ARB_CPU_PRI;
    end else if (contend) begin
      if (wait_cnt != WAIT_MAX) wait_cnt_nxt = wait_cnt + 1'b1;
      if (wait_cnt_nxt == WAIT_MAX) state_nxt = ARB_DMA_PRI;
    end
  end

endmodule
`default_nettype wire

// File: rtl/boneless_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// boneless_mem_arbiter : shares Boneless main memory between the CPU and a DMA port
// Revision: 1.0
// ---------------------------------------------------------------------------
module boneless_mem_arbiter
  import boneless_mem_arb_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cpu_r_adr,
  input  logic          cpu_r_re,
  output logic [DW-1:0] cpu_r_dat,
  input  logic [AW-1:0] cpu_w_adr,
  input  logic [DW-1:0] cpu_w_dat,
  input  logic          cpu_w_we,
  output logic          cpu_stall,
  input  logic [AW-1:0] dma_r_adr,
  input  logic          dma_r_req,
  output logic          dma_r_gnt,
  output logic          dma_r_vld,
  output logic [DW-1:0] dma_r_dat,
  input  logic [AW-1:0] dma_w_adr,
  input  logic [DW-1:0] dma_w_dat,
  input  logic          dma_w_req,
  output logic          dma_w_gnt,
  output logic [AW-1:0] mem_r_adr,
  output logic          mem_r_re,
  input  logic [DW-1:0] mem_r_dat,
  output logic [AW-1:0] mem_w_adr,
  output logic [DW-1:0] mem_w_dat,
  output logic          mem_w_we
);

  logic          rd_cpu_win;
  logic          rd_dma_win;
  logic          wr_cpu_win;
  logic          wr_dma_win;
  logic          cpu_rd;
  logic          cpu_wr;
  logic          cpu_rd_q;
  logic [DW-1:0] rd_hold;

  boneless_arb_port #(.MAX_WAIT(MAX_WAIT)) u_rd_port (
    .clk     (clk),
    .rst     (rst),
    .cpu_req (cpu_r_re),
    .dma_req (dma_r_req),
    .cpu_win (rd_cpu_win),
    .dma_win (rd_dma_win)
  );

  boneless_arb_port #(.MAX_WAIT(MAX_WAIT)) u_wr_port (
    .clk     (clk),
    .rst     (rst),
    .cpu_req (cpu_w_we),
    .dma_req (dma_w_req),
    .cpu_win (wr_cpu_win),
    .dma_win (wr_dma_win)
  );

  // CPU accesses are all-or-nothing: losing either port stalls both.
  assign dma_r_gnt = rd_dma_win & rst;
  assign dma_w_gnt = wr_dma_win & rst;
  assign cpu_stall = dma_r_gnt | dma_w_gnt;
  assign cpu_rd    = rd_cpu_win & rst & ~cpu_stall;
  assign cpu_wr    = wr_cpu_win & rst & ~cpu_stall;

  assign mem_r_re  = cpu_rd | dma_r_gnt;
  assign mem_r_adr = dma_r_gnt ? dma_r_adr : cpu_r_adr;
  assign mem_w_we  = cpu_wr | dma_w_gnt;
  assign mem_w_adr = dma_w_gnt ? dma_w_adr : cpu_w_adr;
  assign mem_w_dat = dma_w_gnt ? dma_w_dat : cpu_w_dat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rd_q  <= 1'b0;
      dma_r_vld <= 1'b0;
      rd_hold   <= '0;
    end else begin
      cpu_rd_q  <= cpu_rd;
      dma_r_vld <= dma_r_gnt;
      if (cpu_rd_q) rd_hold <= mem_r_dat;
    end
  end

  // The hold register keeps CPU data stable across later DMA reads.
  assign cpu_r_dat = cpu_rd_q ? mem_r_dat : rd_hold;
  assign dma_r_dat = mem_r_dat;

endmodule
`default_nettype wire

// File: tb/tb_boneless_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_boneless_mem_arbiter : directed + randomized bench with a behavioural model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_boneless_mem_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int MSZ      = 1024;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_r_adr, cpu_w_adr, cpu_w_dat, dma_r_adr, dma_w_adr, dma_w_dat;
  logic        cpu_r_re, cpu_w_we, dma_r_req, dma_w_req;
  logic [15:0] cpu_r_dat, dma_r_dat, mem_r_adr, mem_w_adr, mem_w_dat;
  logic        cpu_stall, dma_r_gnt, dma_r_vld, dma_w_gnt, mem_r_re, mem_w_we;
  logic [15:0] mem_r_dat;

  boneless_mem_arbiter #(.AW(16), .DW(16), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_r_adr(cpu_r_adr), .cpu_r_re(cpu_r_re), .cpu_r_dat(cpu_r_dat),
    .cpu_w_adr(cpu_w_adr), .cpu_w_dat(cpu_w_dat), .cpu_w_we(cpu_w_we),
    .cpu_stall(cpu_stall),
    .dma_r_adr(dma_r_adr), .dma_r_req(dma_r_req), .dma_r_gnt(dma_r_gnt),
    .dma_r_vld(dma_r_vld), .dma_r_dat(dma_r_dat),
    .dma_w_adr(dma_w_adr), .dma_w_dat(dma_w_dat), .dma_w_req(dma_w_req),
    .dma_w_gnt(dma_w_gnt),
    .mem_r_adr(mem_r_adr), .mem_r_re(mem_r_re), .mem_r_dat(mem_r_dat),
    .mem_w_adr(mem_w_adr), .mem_w_dat(mem_w_dat), .mem_w_we(mem_w_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input int i);
    return 16'(i * 37) ^ 16'hC3A5;
  endfunction

  // Memory array behind the arbiter; fills itself with a pattern first.
  logic [15:0] mem [0:MSZ-1];
  int          init_cnt = 0;
  always @(posedge clk) begin
    if (init_cnt < MSZ) begin
      mem[init_cnt[9:0]] <= pat(init_cnt);
      init_cnt           <= init_cnt + 1;
    end else begin
      if (mem_w_we) mem[mem_w_adr[9:0]] <= mem_w_dat;
      if (mem_r_re) mem_r_dat <= mem[mem_r_adr[9:0]];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  // Reference model: a DMA requester that has lost MAX_WAIT contended
  // cycles in a row on a port is owed that port on the next contention.
  logic [15:0] ref_mem [0:MSZ-1];
  int          starve_r, starve_w;
  logic        m_cr, m_cw, m_dr, m_dw, m_stall;
  logic [15:0] m_rval, m_cpu_dat, m_radr, m_wadr, m_wdat;

  function automatic logic [1:0] arb(input logic c, input logic d, input int starve);
    if (c && d) return (starve >= MAX_WAIT) ? 2'b01 : 2'b10;
    return {c, d};
  endfunction

  function automatic int upd(input logic c, input logic d, input logic dwin, input int s);
    if (dwin) return 0;
    if (c && d) return (s + 1 > MAX_WAIT) ? MAX_WAIT : s + 1;
    return s;
  endfunction

  task automatic model_reset();
    starve_r  = 0;
    starve_w  = 0;
    m_cpu_dat = 16'h0000;
    m_cr = 1'b0; m_cw = 1'b0; m_dr = 1'b0; m_dw = 1'b0; m_stall = 1'b0;
  endtask

  task comb_phase();
    logic [1:0] a_r, a_w;
    #2;
    a_r     = arb(cpu_r_re, dma_r_req, starve_r);
    a_w     = arb(cpu_w_we, dma_w_req, starve_w);
    m_dr    = a_r[0];
    m_dw    = a_w[0];
    m_stall = m_dr | m_dw;
    m_cr    = a_r[1] & ~m_stall;
    m_cw    = a_w[1] & ~m_stall;
    m_radr  = m_dr ? dma_r_adr : cpu_r_adr;
    m_wadr  = m_dw ? dma_w_adr : cpu_w_adr;
    m_wdat  = m_dw ? dma_w_dat : cpu_w_dat;
    chk1("cpu_stall", cpu_stall, m_stall);
    chk1("dma_r_gnt", dma_r_gnt, m_dr);
    chk1("dma_w_gnt", dma_w_gnt, m_dw);
    chk1("mem_r_re", mem_r_re, m_cr | m_dr);
    chk1("mem_w_we", mem_w_we, m_cw | m_dw);
    if (m_cr | m_dr) chk16("mem_r_adr", mem_r_adr, m_radr);
    if (m_cw | m_dw) begin
      chk16("mem_w_adr", mem_w_adr, m_wadr);
      chk16("mem_w_dat", mem_w_dat, m_wdat);
    end
    m_rval = ref_mem[m_radr[9:0]];
    if (m_cw | m_dw) ref_mem[m_wadr[9:0]] = m_wdat;
    starve_r = upd(cpu_r_re, dma_r_req, m_dr, starve_r);
    starve_w = upd(cpu_w_we, dma_w_req, m_dw, starve_w);
  endtask

  task clk_phase();
    @(posedge clk);
    #1;
    chk1("dma_r_vld", dma_r_vld, m_dr);
    if (m_dr) chk16("dma_r_dat", dma_r_dat, m_rval);
    if (m_cr) m_cpu_dat = m_rval;
    chk16("cpu_r_dat", cpu_r_dat, m_cpu_dat);
    @(negedge clk);
  endtask

  task automatic idle();
    cpu_r_re = 1'b0; cpu_w_we = 1'b0; dma_r_req = 1'b0; dma_w_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MSZ; i++) ref_mem[i] = pat(i);
    model_reset();

    // Reset held with every request active.
    rst = 1'b0;
    cpu_r_re = 1'b1; cpu_w_we = 1'b1; dma_r_req = 1'b1; dma_w_req = 1'b1;
    cpu_r_adr = 16'h0001; cpu_w_adr = 16'h0002; cpu_w_dat = 16'h1111;
    dma_r_adr = 16'h0003; dma_w_adr = 16'h0004; dma_w_dat = 16'h2222;
    repeat (MSZ + 4) @(negedge clk);
    chk1("rst_mem_r_re", mem_r_re, 1'b0);
    chk1("rst_mem_w_we", mem_w_we, 1'b0);
    chk1("rst_dma_r_gnt", dma_r_gnt, 1'b0);
    chk1("rst_dma_w_gnt", dma_w_gnt, 1'b0);
    chk1("rst_cpu_stall", cpu_stall, 1'b0);
    chk1("rst_dma_r_vld", dma_r_vld, 1'b0);
    chk16("rst_cpu_r_dat", cpu_r_dat, 16'h0000);
    idle();
    rst = 1'b1;

    // CPU read right after release.
    cpu_r_re = 1'b1; cpu_r_adr = 16'h0010;
    comb_phase();
    chk1("t1_mem_r_re", mem_r_re, 1'b1);
    chk16("t1_mem_r_adr", mem_r_adr, 16'h0010);
    clk_phase();
    idle();

    // Uncontended DMA writes, including the data used by the hold test.
    dma_w_req = 1'b1; dma_w_adr = 16'h1234; dma_w_dat = 16'hBEEF;
    comb_phase();
    chk1("t2_dma_w_gnt", dma_w_gnt, 1'b1);
    chk1("t2_mem_w_we", mem_w_we, 1'b1);
    chk16("t2_mem_w_adr", mem_w_adr, 16'h1234);
    chk16("t2_mem_w_dat", mem_w_dat, 16'hBEEF);
    clk_phase();
    dma_w_adr = 16'h0100; dma_w_dat = 16'hAAAA;
    comb_phase(); clk_phase();
    dma_w_adr = 16'h0101; dma_w_dat = 16'h5555;
    comb_phase(); clk_phase();
    idle();

    // Starvation: CPU reads every cycle, DMA read waits MAX_WAIT cycles.
    for (int c = 0; c < 6; c++) begin
      cpu_r_re = 1'b1; cpu_r_adr = 16'(16'h0040 + c);
      dma_r_req = (c <= 4); dma_r_adr = 16'h0002;
      comb_phase();
      chk1($sformatf("t3_dma_r_gnt_c%0d", c), dma_r_gnt, c == 4);
      chk1($sformatf("t3_cpu_stall_c%0d", c), cpu_stall, c == 4);
      clk_phase();
      chk1($sformatf("t3_dma_r_vld_c%0d", c), dma_r_vld, c == 4);
    end
    idle();

    // All-or-nothing: DMA wins the write port, CPU read is suppressed too.
    for (int c = 0; c < 6; c++) begin
      cpu_r_re = 1'b1; cpu_r_adr = 16'h0020;
      cpu_w_we = 1'b1; cpu_w_adr = 16'h0021; cpu_w_dat = 16'h1111;
      dma_w_req = (c <= 4); dma_w_adr = 16'h0030; dma_w_dat = 16'h2222;
      comb_phase();
      if (c == 4) begin
        chk1("t4_stall", cpu_stall, 1'b1);
        chk1("t4_mem_r_re", mem_r_re, 1'b0);
        chk16("t4_mem_w_adr", mem_w_adr, 16'h0030);
      end else if (c == 5) begin
        chk1("t4_resume_stall", cpu_stall, 1'b0);
        chk1("t4_resume_r_re", mem_r_re, 1'b1);
        chk16("t4_resume_w_adr", mem_w_adr, 16'h0021);
      end
      clk_phase();
    end
    idle();

    // Read-data hold across a DMA read.
    cpu_r_re = 1'b1; cpu_r_adr = 16'h0100;
    comb_phase(); clk_phase();
    chk16("t5_cpu_first", cpu_r_dat, 16'hAAAA);
    cpu_r_re = 1'b0; dma_r_req = 1'b1; dma_r_adr = 16'h0101;
    comb_phase(); clk_phase();
    chk1("t5_dma_vld", dma_r_vld, 1'b1);
    chk16("t5_dma_dat", dma_r_dat, 16'h5555);
    chk16("t5_cpu_held", cpu_r_dat, 16'hAAAA);
    idle();
    comb_phase(); clk_phase();
    chk16("t5_cpu_still", cpu_r_dat, 16'hAAAA);

    // Reset mid-operation with the write port primed for DMA priority.
    for (int c = 0; c < 4; c++) begin
      cpu_w_we = 1'b1; cpu_w_adr = 16'h0050; cpu_w_dat = 16'(c);
      dma_w_req = 1'b1; dma_w_adr = 16'h0051; dma_w_dat = 16'h7777;
      dma_r_req = (c == 3); dma_r_adr = 16'h0003;
      comb_phase();
      if (c == 3) chk1("t6_dma_r_gnt", dma_r_gnt, 1'b1);
      clk_phase();
    end
    chk1("t6_vld_before", dma_r_vld, 1'b1);
    rst = 1'b0;
    #1;
    chk1("t6_vld_async", dma_r_vld, 1'b0);
    chk1("t6_we_in_reset", mem_w_we, 1'b0);
    model_reset();
    dma_r_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    comb_phase();
    chk1("t6_cpu_pri_after", dma_w_gnt, 1'b0);
    chk16("t6_cpu_w_adr", mem_w_adr, 16'h0050);
    clk_phase();
    idle();
    comb_phase(); clk_phase();

    // Randomized traffic under the request-hold rules.
    for (int n = 0; n < 600; n++) begin
      if (!m_stall) begin
        cpu_r_re  = 1'($urandom_range(0, 1));
        cpu_r_adr = 16'($urandom_range(0, 15));
        cpu_w_we  = 1'($urandom_range(0, 1));
        cpu_w_adr = 16'($urandom_range(0, 15));
        cpu_w_dat = 16'($urandom);
      end
      if (!dma_r_req || m_dr) begin
        dma_r_req = ($urandom_range(0, 2) == 0);
        dma_r_adr = 16'($urandom_range(0, 15));
      end
      if (!dma_w_req || m_dw) begin
        dma_w_req = ($urandom_range(0, 2) == 0);
        dma_w_adr = 16'($urandom_range(0, 15));
        dma_w_dat = 16'($urandom);
      end
      comb_phase();
      clk_phase();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
